median_window_ctrl: RTL
=======================

Name: median_window_ctrl

Overview:
- Sequencer for the 5x5 median datapath.
- Tracks AXI4-Stream video (tuser = SOF, tlast = EOL) pixel position and generates line-buffer/window shift enables.
- Computes the window-centre coordinate and issues output-side valid/tuser/tlast, delayed by the kernel's spatial latency.
- After the last pixel of a frame, drains the window with internal flush steps so every input pixel yields exactly one output pixel.

Parameters:
- IMG_WIDTH, 1280, pixels per line (>= KERNEL_SIZE).
- IMG_HEIGHT, 1024, lines per frame (>= KERNEL_SIZE).
- KERNEL_SIZE, 5, odd window size. R = KERNEL_SIZE/2.
- Derived constant: D = R*IMG_WIDTH + R, the centre lag in steps (2562 at defaults).

Ports:
- i_clk  in  1  system clock.
- i_areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- s_axis_tready  out  1  input ready.
- o_step  out  1  advance line buffers/window by one pixel.
- o_flush  out  1  current step is a flush step; datapath feeds pad data.
- o_lb_wr_addr  out  $clog2(IMG_WIDTH)  input column, used as line-buffer address.
- o_center_x  out  $clog2(IMG_WIDTH)  window-centre column, for border handling.
- o_center_y  out  $clog2(IMG_HEIGHT)  window-centre row.
- o_win_valid  out  1  window centred on a real pixel; drives m_axis_tvalid.
- o_tuser  out  1  qualifies o_win_valid at centre (0,0).
- o_tlast  out  1  qualifies o_win_valid at centre x = IMG_WIDTH-1.
- o_busy  out  1  not IDLE.
- o_sof_err  out  1  one-cycle pulse on unexpected tuser.
- o_eol_err  out  1  one-cycle pulse on tlast/column mismatch.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. An asserted reset mid-frame abandons the frame with no flush.
- Handshake: accept = s_axis_tvalid & s_axis_tready. No output backpressure; downstream always accepts.
- States:
  - IDLE: tready = 1. Non-tuser beats are discarded (no o_step). An accepted beat with tuser sets x_in = y_in = 0, step_cnt = 0 and goes to RUN; that beat is step 0.
  - RUN: tready = 1. Each accept is one step. x_in wraps at IMG_WIDTH-1 and increments y_in. Accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1) goes to FLUSH.
  - FLUSH: tready = 0. One step per cycle with o_flush = 1, for exactly D cycles, then IDLE.
- Step outputs: o_step, o_lb_wr_addr and o_flush are registered, valid one cycle after the accept/flush cycle (latency 1).
- Centre tracking:
  - A step with step_cnt >= D also asserts o_win_valid in the same registered cycle.
  - It advances the centre counters (raster order, wrap at IMG_WIDTH / IMG_HEIGHT).
  - o_center_x/y hold the coordinate of the current o_win_valid.
  - o_tuser = o_win_valid & centre == (0,0).
  - o_tlast = o_win_valid & centre_x == IMG_WIDTH-1.
  - Total o_win_valid per frame = IMG_WIDTH*IMG_HEIGHT exactly.
- Error handling:
  - tuser accepted in RUN at a position other than (0,0): pulse o_sof_err, abandon the frame (no flush), restart the frame with this beat as step 0.
  - tlast disagreeing with x_in == IMG_WIDTH-1: pulse o_eol_err. Counters follow parameters, not tlast.
- Arithmetic: step_cnt width $clog2(IMG_WIDTH*IMG_HEIGHT+D). Saturates, never wraps within a frame.
- Simultaneous events:
  - tuser accepted on the final RUN pixel: the SOF error path wins, no FLUSH.
  - tvalid during FLUSH is ignored (tready = 0); the source holds the beat.

Decomposition:
- Package median_pkg:
  - function clog2-based widths.
  - localparam computation of R and D.
  - typedef enum logic [1:0] {IDLE, RUN, FLUSH} ctrl_state_t.
- Optional sub-module raster_counter: parameterised x/y counter with enable, clear and wrap flags. Instantiated twice, for input position and centre position.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL_SIZE=5, so D=18):
1. Continuous 48-pixel frame with tuser on first, tlast every 8th:
   - o_step x66, o_win_valid x48.
   - First o_win_valid on 19th step with o_tuser=1, centre (0,0).
   - o_tlast x6.
   - tready low for exactly 18 cycles, then IDLE.
2. Random tvalid gaps (50%) on the same frame: identical o_win_valid/o_tuser/o_tlast sequence, no o_step on idle cycles.
3. Three pixels without tuser, then a frame: the 3 pixels produce no o_step; the frame behaves as in case 1.
4. tuser reasserted at pixel 20 of a frame: o_sof_err pulses once; new frame counts from 0 and completes with 48 valids.
5. tlast at x=5 of line 2: o_eol_err pulses once; centre sequence unchanged.
6. i_areset asserted during FLUSH cycle 7: all outputs 0 next edge; after release, IDLE with tready=1.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and width/geometry helpers for the 5x5 median window sequencer.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_r(input int kernel_size);
        return kernel_size / 2;
    endfunction

    // Centre lag in steps: R full lines plus R pixels.
    function automatic int calc_d(input int img_width, input int kernel_size);
        return calc_r(kernel_size) * img_width + calc_r(kernel_size);
    endfunction

endpackage

// File: rtl/median_window_ctrl_raster_counter.sv
// Raster-order x/y position counter; clear restarts at (0,0) and may coincide with an advance.
module raster_counter
    import median_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 6,
    localparam int XW = width_of(WIDTH),
    localparam int YW = width_of(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          x_last,
    output logic          frame_last
);

    logic [XW-1:0] base_x, x_next;
    logic [YW-1:0] base_y, y_next;

    assign x_last     = (x == XW'(WIDTH - 1));
    assign frame_last = x_last && (y == YW'(HEIGHT - 1));

    always_comb begin
        base_x = clr ? '0 : x;
        base_y = clr ? '0 : y;
        x_next = base_x;
        y_next = base_y;
        if (en) begin
            if (base_x == XW'(WIDTH - 1)) begin
                x_next = '0;
                y_next = (base_y == YW'(HEIGHT - 1)) ? '0 : base_y + 1'b1;
            end else begin
                x_next = base_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_next;
            y <= y_next;
        end
    end

endmodule

// File: rtl/median_window_ctrl.sv
// Sequencer for the median window: tracks input raster position, issues step/flush
// enables and the centre-aligned output valid/tuser/tlast, draining D pad steps per frame.
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int IMG_WIDTH   = 1280,
    parameter int IMG_HEIGHT  = 1024,
    parameter int KERNEL_SIZE = 5,
    localparam int XW = width_of(IMG_WIDTH),
    localparam int YW = width_of(IMG_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_areset,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tuser,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic          o_step,
    output logic          o_flush,
    output logic [XW-1:0] o_lb_wr_addr,
    output logic [XW-1:0] o_center_x,
    output logic [YW-1:0] o_center_y,
    output logic          o_win_valid,
    output logic          o_tuser,
    output logic          o_tlast,
    output logic          o_busy,
    output logic          o_sof_err,
    output logic          o_eol_err,
    output ctrl_state_t   o_state
);

    localparam int D  = calc_d(IMG_WIDTH, KERNEL_SIZE);
    localparam int CW = width_of(IMG_WIDTH * IMG_HEIGHT + D);
    localparam int FW = width_of(D);
    localparam logic [CW-1:0] D_CNT      = CW'(D);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(D - 1);

    ctrl_state_t   state, state_next;
    logic [CW-1:0] step_cnt, step_idx, step_cnt_next;
    logic [FW-1:0] flush_cnt, flush_cnt_next;

    logic          accept, step, flush, restart, sof_err, eol_chk, win_valid;
    logic [XW-1:0] in_x, step_x, c_x;
    logic [YW-1:0] in_y, c_y;
    logic          in_x_last, in_frame_last, c_x_last, c_last_unused;

    // Beat transfers when s_axis_tvalid and s_axis_tready are both high at a rising
    // edge; tready is independent of tvalid and drops only while draining or in reset.
    assign s_axis_tready = ~i_areset & (state != FLUSH);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign o_busy        = (state != IDLE);
    assign o_state       = state;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        step           = 1'b0;
        flush          = 1'b0;
        restart        = 1'b0;
        sof_err        = 1'b0;
        eol_chk        = 1'b0;
        case (state)
            IDLE: begin
                flush_cnt_next = '0;
                if (accept && s_axis_tuser) begin
                    step       = 1'b1;
                    restart    = 1'b1;
                    eol_chk    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    step    = 1'b1;
                    eol_chk = 1'b1;
                    // A misplaced SOF beat takes priority over frame completion.
                    if (s_axis_tuser && !(in_x == '0 && in_y == '0)) begin
                        restart = 1'b1;
                        sof_err = 1'b1;
                    end else if (in_frame_last) begin
                        state_next     = FLUSH;
                        flush_cnt_next = '0;
                    end
                end
            end
            FLUSH: begin
                step  = 1'b1;
                flush = 1'b1;
                if (flush_cnt == FLUSH_LAST) begin
                    state_next = IDLE;
                end else begin
                    flush_cnt_next = flush_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A restart beat is step 0 at column 0, whatever the counters held.
    always_comb begin
        step_x        = restart ? '0 : in_x;
        step_idx      = restart ? '0 : step_cnt;
        step_cnt_next = (&step_idx) ? step_idx : step_idx + 1'b1;
        win_valid     = step && (step_idx >= D_CNT);
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state     <= IDLE;
            flush_cnt <= '0;
            step_cnt  <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (step) begin
                step_cnt <= step_cnt_next;
            end
        end
    end

    raster_counter #(.WIDTH(IMG_WIDTH), .HEIGHT(IMG_HEIGHT)) u_in_pos (
        .clk        (i_clk),
        .rst        (i_areset),
        .clr        (restart),
        .en         (step),
        .x          (in_x),
        .y          (in_y),
        .x_last     (in_x_last),
        .frame_last (in_frame_last)
    );

    raster_counter #(.WIDTH(IMG_WIDTH), .HEIGHT(IMG_HEIGHT)) u_center_pos (
        .clk        (i_clk),
        .rst        (i_areset),
        .clr        (restart),
        .en         (win_valid),
        .x          (c_x),
        .y          (c_y),
        .x_last     (c_x_last),
        .frame_last (c_last_unused)
    );

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_step       <= 1'b0;
            o_flush      <= 1'b0;
            o_lb_wr_addr <= '0;
            o_center_x   <= '0;
            o_center_y   <= '0;
            o_win_valid  <= 1'b0;
            o_tuser      <= 1'b0;
            o_tlast      <= 1'b0;
            o_sof_err    <= 1'b0;
            o_eol_err    <= 1'b0;
        end else begin
            o_step      <= step;
            o_flush     <= flush;
            o_win_valid <= win_valid;
            o_tuser     <= win_valid && (c_x == '0) && (c_y == '0);
            o_tlast     <= win_valid && c_x_last;
            o_sof_err   <= sof_err;
            o_eol_err   <= eol_chk && (s_axis_tlast != (step_x == XW'(IMG_WIDTH - 1)));
            if (step) begin
                o_lb_wr_addr <= step_x;
            end
            if (win_valid) begin
                o_center_x <= c_x;
                o_center_y <= c_y;
            end
        end
    end

    // Column flag of the input counter is only needed through step_x comparisons.
    logic in_x_last_unused;
    assign in_x_last_unused = in_x_last;

endmodule
